memory_bus_arbiter: RTL and testbench

- Shares the single-port synchronous word memory between two bus masters: m0 (the CPU core) and m1 (DMA or debug/dump engine).
- Each master performs single-word accesses through a req/ack handshake.
- The block runs round-robin arbitration with an optional lock, bounded by an anti-starvation counter.
- It flags out-of-range and malformed accesses as bus errors without touching memory.

---
 rtl/memory_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// Two-master arbiter for a single-port synchronous word memory: round-robin with
// bounded lock, three-cycle IDLE/ACCESS/RESPOND transaction, bus-error rejection.

module memory_bus_arbiter_check #(
  parameter int MEM_WORDS = 4096
) (
  input  logic [29:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  strobes,
  output logic        error
);
  // Malformed or out-of-range accesses never reach the memory.
  assign error = ({1'b0, address} >= 31'(MEM_WORDS)) | (read == write) |
                 (write & (strobes == 4'b0000));
endmodule

module memory_bus_arbiter #(
  parameter int MEM_WORDS = 4096,
  parameter int MAX_LOCK  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [29:0] m0_address,
  input  logic [31:0] m0_data_out,
  input  logic [3:0]  m0_data_strobes,
  input  logic        m0_read,
  input  logic        m0_write,
  output logic [31:0] m0_data_in,
  output logic        m0_ack,
  output logic        m0_bus_error,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [29:0] m1_address,
  input  logic [31:0] m1_data_out,
  input  logic [3:0]  m1_data_strobes,
  input  logic        m1_read,
  input  logic        m1_write,
  output logic [31:0] m1_data_in,
  output logic        m1_ack,
  output logic        m1_bus_error,
  output logic [29:0] address,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  output logic [3:0]  data_strobes,
  output logic        read,
  output logic        write
);
  localparam int NUM_MASTERS = 2;
  localparam int LCW = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t state, state_nxt;

  logic [NUM_MASTERS-1:0]        req, lock, rd, wr, err;
  logic [NUM_MASTERS-1:0][29:0]  addr;
  logic [NUM_MASTERS-1:0][31:0]  wdata;
  logic [NUM_MASTERS-1:0][3:0]   strb;

  logic           owner, owner_err, last_owner, lock_held;
  logic [LCW-1:0] lock_count;
  logic           grant, locked, start, resp;

  assign req   = {m1_req, m0_req};
  assign lock  = {m1_lock, m0_lock};
  assign rd    = {m1_read, m0_read};
  assign wr    = {m1_write, m0_write};
  assign addr  = {m1_address, m0_address};
  assign wdata = {m1_data_out, m0_data_out};
  assign strb  = {m1_data_strobes, m0_data_strobes};

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_port
    memory_bus_arbiter_check #(.MEM_WORDS(MEM_WORDS)) u_check (
      .address (addr[g]),
      .read    (rd[g]),
      .write   (wr[g]),
      .strobes (strb[g]),
      .error   (err[g])
    );
  end

  // Contention goes to the non-last owner unless a still-budgeted lock holds it.
  always_comb begin
    grant  = req[1];
    locked = 1'b0;
    if (req[0] && req[1]) begin
      if (lock_held && (lock_count < LCW'(MAX_LOCK))) begin
        grant  = last_owner;
        locked = 1'b1;
      end else begin
        grant  = ~last_owner;
      end
    end
  end

  assign start = (state == IDLE) && (|req);
  assign resp  = (state == RESPOND);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner        <= 1'b0;
      owner_err    <= 1'b0;
      last_owner   <= 1'b1;
      lock_held    <= 1'b0;
      lock_count   <= '0;
      address      <= '0;
      data_out     <= '0;
      data_strobes <= '0;
      read         <= 1'b0;
      write        <= 1'b0;
    end else begin
      if (start) begin
        owner      <= grant;
        owner_err  <= err[grant];
        last_owner <= grant;
        lock_count <= locked ? lock_count + LCW'(1) : '0;
        if (!err[grant]) begin
          address      <= addr[grant];
          data_out     <= wdata[grant];
          data_strobes <= strb[grant];
          read         <= rd[grant];
          write        <= wr[grant];
        end
      end
      if (state == ACCESS) begin
        address      <= '0;
        data_out     <= '0;
        data_strobes <= '0;
        read         <= 1'b0;
        write        <= 1'b0;
      end
      // Lock intent is whatever the owner presents during its ack cycle.
      if (resp) lock_held <= lock[owner];
    end
  end

  assign m0_ack       = resp & ~owner;
  assign m1_ack       = resp & owner;
  assign m0_bus_error = m0_ack & owner_err;
  assign m1_bus_error = m1_ack & owner_err;
  assign m0_data_in   = (m0_ack && !owner_err) ? data_in : '0;
  assign m1_data_in   = (m1_ack && !owner_err) ? data_in : '0;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter with a small behavioural word memory.

module tb_memory_bus_arbiter;
  logic        clock, reset;
  logic        m0_req, m0_lock, m0_read, m0_write;
  logic [29:0] m0_address;
  logic [31:0] m0_data_out, m0_data_in;
  logic [3:0]  m0_data_strobes;
  logic        m0_ack, m0_bus_error;
  logic        m1_req, m1_lock, m1_read, m1_write;
  logic [29:0] m1_address;
  logic [31:0] m1_data_out, m1_data_in;
  logic [3:0]  m1_data_strobes;
  logic        m1_ack, m1_bus_error;
  logic [29:0] address;
  logic [31:0] data_out;
  logic [31:0] data_in = 32'hA5A5_A5A5;
  logic [3:0]  data_strobes;
  logic        read, write;

  logic [31:0] mem [0:4095];
  int strobe_cnt = 0;
  int passed = 0;
  int total = 0;

  memory_bus_arbiter #(.MEM_WORDS(4096), .MAX_LOCK(8)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_address(m0_address),
    .m0_data_out(m0_data_out), .m0_data_strobes(m0_data_strobes),
    .m0_read(m0_read), .m0_write(m0_write), .m0_data_in(m0_data_in),
    .m0_ack(m0_ack), .m0_bus_error(m0_bus_error),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_address(m1_address),
    .m1_data_out(m1_data_out), .m1_data_strobes(m1_data_strobes),
    .m1_read(m1_read), .m1_write(m1_write), .m1_data_in(m1_data_in),
    .m1_ack(m1_ack), .m1_bus_error(m1_bus_error),
    .address(address), .data_out(data_out), .data_in(data_in),
    .data_strobes(data_strobes), .read(read), .write(write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory: read data appears the cycle after read is high.
  always @(posedge clock) begin
    if (write)
      for (int b = 0; b < 4; b++)
        if (data_strobes[b]) mem[address[11:0]][8*b +: 8] <= data_out[8*b +: 8];
    if (read) data_in <= mem[address[11:0]];
    if (read || write) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic set_m0(input logic rq, lk, rd, wr, input logic [29:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    m0_req = rq; m0_lock = lk; m0_read = rd; m0_write = wr;
    m0_address = a; m0_data_out = d; m0_data_strobes = s;
  endtask

  task automatic set_m1(input logic rq, lk, rd, wr, input logic [29:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    m1_req = rq; m1_lock = lk; m1_read = rd; m1_write = wr;
    m1_address = a; m1_data_out = d; m1_data_strobes = s;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    set_m0(0, 0, 0, 0, '0, '0, '0);
    set_m1(0, 0, 0, 0, '0, '0, '0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_m0(0, 0, 0, 0, '0, '0, '0);
    set_m1(0, 0, 0, 0, '0, '0, '0);
    @(posedge clock); #1;
    total++; if ({read, write, data_strobes} !== 6'b0) $display("FAIL reset_strobes: got %b want 0", {read, write, data_strobes}); else passed++;
    total++; if ({address, data_out} !== 62'b0) $display("FAIL reset_mem_bus: got %h want 0", {address, data_out}); else passed++;
    total++; if ({m0_ack, m0_bus_error, m1_ack, m1_bus_error} !== 4'b0) $display("FAIL reset_acks: got %b want 0", {m0_ack, m0_bus_error, m1_ack, m1_bus_error}); else passed++;
    total++; if ({m0_data_in, m1_data_in} !== 64'b0) $display("FAIL reset_rdata: got %h want 0", {m0_data_in, m1_data_in}); else passed++;
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_write_read();
    set_m0(1, 0, 0, 1, 30'h10, 32'hDEAD_BEEF, 4'hF);
    step();
    total++; if ({write, read, address, data_out, data_strobes} !== {1'b1, 1'b0, 30'h10, 32'hDEAD_BEEF, 4'hF})
      $display("FAIL wr_access: got w%b r%b a%h d%h s%h want w1 r0 a10 ddeadbeef sf", write, read, address, data_out, data_strobes); else passed++;
    total++; if (m0_ack !== 1'b0) $display("FAIL wr_early_ack: got %b want 0", m0_ack); else passed++;
    step();
    total++; if ({m0_ack, m0_bus_error, m1_ack, write} !== 4'b1000) $display("FAIL wr_respond: got %b want 1000", {m0_ack, m0_bus_error, m1_ack, write}); else passed++;
    set_m0(1, 0, 1, 0, 30'h10, '0, '0);
    step();
    total++; if (read !== 1'b0) $display("FAIL rd_idle_gap: got %b want 0", read); else passed++;
    step();
    total++; if ({read, address} !== {1'b1, 30'h10}) $display("FAIL rd_access: got r%b a%h want r1 a10", read, address); else passed++;
    step();
    total++; if ({m0_ack, m0_bus_error, m0_data_in} !== {2'b10, 32'hDEAD_BEEF}) $display("FAIL rd_data: got ack%b err%b %h want ack1 err0 deadbeef", m0_ack, m0_bus_error, m0_data_in); else passed++;
    set_m0(0, 0, 0, 0, '0, '0, '0);
    step();
  endtask

  task automatic test_byte_write();
    set_m0(1, 0, 0, 1, 30'h30, 32'h1122_3344, 4'hF);
    step(); step();
    set_m0(1, 0, 0, 1, 30'h30, 32'h0000_AB00, 4'b0010);
    step(); step();
    total++; if (data_strobes !== 4'b0010) $display("FAIL byte_strobes: got %b want 0010", data_strobes); else passed++;
    step();
    set_m0(1, 0, 1, 0, 30'h30, '0, '0);
    step(); step(); step();
    total++; if ({m0_ack, m0_data_in} !== {1'b1, 32'h1122_AB44}) $display("FAIL byte_readback: got ack%b %h want ack1 1122ab44", m0_ack, m0_data_in); else passed++;
    set_m0(0, 0, 0, 0, '0, '0, '0);
    step();
  endtask

  task automatic test_alternate();
    logic [65:0] exp_v;
    apply_reset();
    set_m0(1, 0, 1, 0, 30'h10, '0, '0);
    set_m1(1, 0, 1, 0, 30'h30, '0, '0);
    for (int k = 0; k < 6; k++) begin
      step(); step();
      exp_v = (k % 2 == 0) ? {2'b10, 32'hDEAD_BEEF, 32'h0} : {2'b01, 32'h0, 32'h1122_AB44};
      total++; if ({m0_ack, m1_ack, m0_data_in, m1_data_in} !== exp_v)
        $display("FAIL alternate_%0d: got %h want %h", k, {m0_ack, m1_ack, m0_data_in, m1_data_in}, exp_v); else passed++;
      step();
    end
    set_m0(0, 0, 0, 0, '0, '0, '0);
    set_m1(0, 0, 0, 0, '0, '0, '0);
    step();
  endtask

  task automatic test_lock();
    logic [1:0] exp_a;
    apply_reset();
    set_m0(1, 1, 1, 0, 30'h10, '0, '0);
    set_m1(1, 0, 1, 0, 30'h30, '0, '0);
    // 1 initial + 8 locked grants to m0, forced switch to m1, then m0 locks afresh.
    for (int k = 0; k < 12; k++) begin
      step(); step();
      exp_a = (k == 9) ? 2'b01 : 2'b10;
      total++; if ({m0_ack, m1_ack} !== exp_a) $display("FAIL lock_grant_%0d: got %b want %b", k, {m0_ack, m1_ack}, exp_a); else passed++;
      step();
    end
    set_m0(0, 0, 0, 0, '0, '0, '0);
    set_m1(0, 0, 0, 0, '0, '0, '0);
    step();
  endtask

  task automatic test_errors();
    int snap;
    apply_reset();
    snap = strobe_cnt;
    set_m1(1, 0, 1, 0, 30'd4096, '0, '0);
    step();
    total++; if ({read, write} !== 2'b00) $display("FAIL err_range_strobe: got %b want 00", {read, write}); else passed++;
    step();
    total++; if ({m1_ack, m1_bus_error, m0_ack, m1_data_in} !== {3'b110, 32'h0}) $display("FAIL err_range: got %b %h want 110 0", {m1_ack, m1_bus_error, m0_ack}, m1_data_in); else passed++;
    set_m1(0, 0, 0, 0, '0, '0, '0);
    set_m0(1, 0, 1, 1, 30'h5, 32'h1, 4'hF);
    step(); step(); step();
    total++; if ({m0_ack, m0_bus_error, m0_data_in} !== {2'b11, 32'h0}) $display("FAIL err_rw_both: got %b%b %h want 11 0", m0_ack, m0_bus_error, m0_data_in); else passed++;
    set_m0(1, 0, 0, 1, 30'h5, 32'h1, 4'h0);
    step(); step(); step();
    total++; if ({m0_ack, m0_bus_error} !== 2'b11) $display("FAIL err_no_strobes: got %b want 11", {m0_ack, m0_bus_error}); else passed++;
    set_m0(1, 0, 0, 0, 30'h5, 32'h1, 4'hF);
    step(); step(); step();
    total++; if ({m0_ack, m0_bus_error} !== 2'b11) $display("FAIL err_rw_none: got %b want 11", {m0_ack, m0_bus_error}); else passed++;
    set_m0(0, 0, 0, 0, '0, '0, '0);
    step(); step();
    total++; if (strobe_cnt !== snap) $display("FAIL err_mem_touched: got %0d want %0d", strobe_cnt, snap); else passed++;
    set_m1(1, 0, 1, 0, 30'd4095, '0, '0);
    step();
    total++; if ({read, address} !== {1'b1, 30'd4095}) $display("FAIL last_word_access: got r%b a%h want r1 a%h", read, address, 30'd4095); else passed++;
    step();
    total++; if ({m1_ack, m1_bus_error} !== 2'b10) $display("FAIL last_word_resp: got %b want 10", {m1_ack, m1_bus_error}); else passed++;
    set_m1(0, 0, 0, 0, '0, '0, '0);
    step();
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    set_m1(1, 0, 0, 1, 30'h40, 32'h1234_5678, 4'hF);
    step();
    total++; if (write !== 1'b1) $display("FAIL rst_pre_write: got %b want 1", write); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if ({read, write, data_strobes, address, data_out, m1_ack, m1_bus_error} !== 70'b0)
      $display("FAIL rst_async_clear: got %h want 0", {read, write, data_strobes, address, data_out, m1_ack, m1_bus_error}); else passed++;
    set_m0(1, 0, 1, 0, 30'h10, '0, '0);
    step();
    total++; if ({m0_ack, m1_ack} !== 2'b00) $display("FAIL rst_no_ack: got %b want 00", {m0_ack, m1_ack}); else passed++;
    @(negedge clock); reset = 1'b1;
    step(); step();
    total++; if ({m0_ack, m1_ack, m0_data_in} !== {2'b10, 32'hDEAD_BEEF}) $display("FAIL rst_first_m0: got %b %h want 10 deadbeef", {m0_ack, m1_ack}, m0_data_in); else passed++;
    step(); step(); step();
    total++; if ({m0_ack, m1_ack, m1_bus_error} !== 3'b010) $display("FAIL rst_then_m1: got %b want 010", {m0_ack, m1_ack, m1_bus_error}); else passed++;
    set_m0(0, 0, 0, 0, '0, '0, '0);
    set_m1(0, 0, 0, 0, '0, '0, '0);
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_alternate();
    test_lock();
    test_errors();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
